// File: rtl/call_return_ctrl_if.sv
// Bundle of control-unit, stack, PC-unit and register-file signals seen by call_return_ctrl.
// The slave modport is the sequencer; master is whatever surrounds it.
interface call_return_ctrl_if #(
  parameter int DW = 19
);
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_code;
  logic [DW-1:0] pc_curr;
  logic [DW-1:0] target_addr;
  logic [DW-1:0] reg_data;

  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_push_data;
  logic [DW-1:0] stk_pop_data;
  logic          stk_empty;
  logic          stk_full;

  logic          done;
  logic          pc_load;
  logic [DW-1:0] pc_next;
  logic          reg_wr;
  logic [DW-1:0] reg_wdata;

  logic          fault;
  logic          fault_ovf;
  logic          fault_unf;
  logic          clear_fault;

  modport slave (
    input  op_valid, op_code, pc_curr, target_addr, reg_data,
    input  stk_pop_data, stk_empty, stk_full, clear_fault,
    output op_ready, stk_push, stk_pop, stk_push_data,
    output done, pc_load, pc_next, reg_wr, reg_wdata,
    output fault, fault_ovf, fault_unf
  );

  modport master (
    output op_valid, op_code, pc_curr, target_addr, reg_data,
    output stk_pop_data, stk_empty, stk_full, clear_fault,
    input  op_ready, stk_push, stk_pop, stk_push_data,
    input  done, pc_load, pc_next, reg_wr, reg_wdata,
    input  fault, fault_ovf, fault_unf
  );
endinterface

// File: rtl/call_return_ctrl.sv
// CALL/RET/PUSH/POP sequencer in front of the hardware stack: issues single-cycle
// push/pop strobes, forms return addresses and PC/register results, traps over/underflow.
module call_return_ctrl #(
  parameter int DW      = 19,
  parameter int RET_OFS = 1
) (
  input logic                 clk,
  input logic                 reset,
  call_return_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_CALL = 2'b00,
    OP_RET  = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  state_e        state_q;
  op_e           op_q;
  logic [DW-1:0] target_q;
  logic [DW-1:0] push_data_q;
  logic [DW-1:0] pc_next_q;
  logic [DW-1:0] reg_wdata_q;
  logic          op_ready_q;
  logic          done_q;
  logic          pc_load_q;
  logic          reg_wr_q;
  logic          fault_q;
  logic          fault_ovf_q;
  logic          fault_unf_q;

  logic          in_exec;
  logic          op_pushes;
  logic          ovf_hit;
  logic          unf_hit;

  assign in_exec   = (state_q == S_EXEC);
  assign op_pushes = (op_q == OP_CALL) || (op_q == OP_PUSH);
  assign ovf_hit   = op_pushes && bus.stk_full;
  assign unf_hit   = !op_pushes && bus.stk_empty;

  // Strobes depend on the live stack flags so a trapped op never touches the stack.
  assign bus.stk_push      = in_exec && op_pushes && !bus.stk_full;
  assign bus.stk_pop       = in_exec && !op_pushes && !bus.stk_empty;
  assign bus.stk_push_data = push_data_q;

  assign bus.op_ready  = op_ready_q;
  assign bus.done      = done_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.pc_next   = pc_next_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.fault     = fault_q;
  assign bus.fault_ovf = fault_ovf_q;
  assign bus.fault_unf = fault_unf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_CALL;
      target_q    <= '0;
      push_data_q <= '0;
      pc_next_q   <= '0;
      reg_wdata_q <= '0;
      op_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      pc_load_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
      fault_q     <= 1'b0;
      fault_ovf_q <= 1'b0;
      fault_unf_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pc_load_q <= 1'b0;
      reg_wr_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.op_valid && op_ready_q) begin
            op_q       <= op_e'(bus.op_code);
            target_q   <= bus.target_addr;
            // Return address is formed here so EXEC only has to select the push word.
            if (op_e'(bus.op_code) == OP_CALL) begin
              push_data_q <= bus.pc_curr + DW'(RET_OFS);
            end else begin
              push_data_q <= bus.reg_data;
            end
            op_ready_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ovf_hit) begin
            fault_q     <= 1'b1;
            fault_ovf_q <= 1'b1;
            state_q     <= S_FAULT;
          end else if (unf_hit) begin
            fault_q     <= 1'b1;
            fault_unf_q <= 1'b1;
            state_q     <= S_FAULT;
          end else begin
            done_q    <= 1'b1;
            pc_load_q <= (op_q == OP_CALL) || (op_q == OP_RET);
            reg_wr_q  <= (op_q == OP_POP);
            unique case (op_q)
              OP_CALL: pc_next_q   <= target_q;
              OP_RET:  pc_next_q   <= bus.stk_pop_data;
              OP_POP:  reg_wdata_q <= bus.stk_pop_data;
              OP_PUSH: ;
            endcase
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          op_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        S_FAULT: begin
          if (bus.clear_fault) begin
            fault_q     <= 1'b0;
            fault_ovf_q <= 1'b0;
            fault_unf_q <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
